// File: rtl/matmul_stream_ctrl.sv
// Host-side sequencer for a 2x2 signed-8-bit systolic multiplier: streams in 8 operand bytes,
// kicks the array, captures its four 17-bit results and streams them back out.
module matmul_stream_ctrl #(
    parameter int TIMEOUT    = 15,
    parameter int KICK_CYCLS = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    output logic [7:0]  a11,
    output logic [7:0]  a12,
    output logic [7:0]  a21,
    output logic [7:0]  a22,
    output logic [7:0]  b11,
    output logic [7:0]  b12,
    output logic [7:0]  b21,
    output logic [7:0]  b22,
    output logic        arr_rst,
    input  logic        arr_done,
    input  logic [16:0] c11,
    input  logic [16:0] c12,
    input  logic [16:0] c21,
    input  logic [16:0] c22,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [16:0] out_data,
    output logic [1:0]  out_idx,
    output logic        busy,
    output logic        err
);
    localparam int KW = (KICK_CYCLS < 2) ? 1 : $clog2(KICK_CYCLS);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_KICK, S_WAIT, S_DRAIN} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [7:0]    r_ops [8];
    logic [2:0]    r_cnt;
    logic [KW-1:0] r_kcnt;
    logic [TW-1:0] r_tcnt;
    logic [16:0]   r_cap [4];
    logic [1:0]    r_idx;
    logic          r_err;

    logic w_in_fire;
    logic w_out_fire;
    logic w_done_ok;
    logic w_timeout;
    logic w_capture;

    // The first WAIT cycle is ignored so a done level left over from the previous job cannot leak in.
    assign w_done_ok  = (r_state == S_WAIT) && arr_done && (r_tcnt != '0);
    assign w_timeout  = (r_state == S_WAIT) && !w_done_ok && (r_tcnt == TW'(TIMEOUT));
    assign w_capture  = w_done_ok || w_timeout;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_in_fire) w_next = S_LOAD;
            S_LOAD:  if (w_in_fire && (r_cnt == 3'd7)) w_next = S_KICK;
            S_KICK:  if (r_kcnt == KW'(KICK_CYCLS - 1)) w_next = S_WAIT;
            S_WAIT:  if (w_capture) w_next = S_DRAIN;
            S_DRAIN: if (w_out_fire && (r_idx == 2'd3)) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = !rst && ((r_state == S_IDLE) || (r_state == S_LOAD));
        arr_rst   = rst || (r_state == S_IDLE) || (r_state == S_LOAD) || (r_state == S_KICK);
        out_valid = !rst && (r_state == S_DRAIN);
        out_data  = r_cap[r_idx];
        out_idx   = r_idx;
        busy      = (r_state != S_IDLE);
        err       = r_err;
    end

    // NOTE: the operand and capture arrays are reset because their values are visible on ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_kcnt  <= '0;
            r_tcnt  <= '0;
            r_idx   <= '0;
            r_err   <= 1'b0;
            for (int i = 0; i < 8; i++) r_ops[i] <= '0;
            for (int i = 0; i < 4; i++) r_cap[i] <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (w_in_fire) begin
                    r_ops[0] <= in_data;
                    r_cnt    <= 3'd1;
                    r_err    <= 1'b0;
                end
                S_LOAD: if (w_in_fire) begin
                    r_ops[r_cnt] <= in_data;
                    r_cnt        <= r_cnt + 3'd1;
                    r_kcnt       <= '0;
                end
                S_KICK: begin
                    r_kcnt <= r_kcnt + KW'(1);
                    r_tcnt <= '0;
                end
                S_WAIT: begin
                    r_tcnt <= r_tcnt + TW'(1);
                    if (w_capture) begin
                        r_cap[0] <= c11;
                        r_cap[1] <= c12;
                        r_cap[2] <= c21;
                        r_cap[3] <= c22;
                        r_idx    <= '0;
                    end
                    if (w_timeout) r_err <= 1'b1;
                end
                S_DRAIN: if (w_out_fire) r_idx <= r_idx + 2'd1;
                default: ;
            endcase
        end
    end

    assign a11 = r_ops[0];
    assign a12 = r_ops[1];
    assign a21 = r_ops[2];
    assign a22 = r_ops[3];
    assign b11 = r_ops[4];
    assign b12 = r_ops[5];
    assign b21 = r_ops[6];
    assign b22 = r_ops[7];
endmodule

// File: tb/tb_matmul_stream_ctrl.sv
// Directed bench for matmul_stream_ctrl with a behavioural 2x2 array model
// (done rises 6 cycles after arr_rst falls; can be forced stuck low).
module tb_matmul_stream_ctrl;
    localparam int TIMEOUT = 15;
    localparam int KICK    = 2;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, arr_rst, arr_done;
    logic        out_valid, out_ready, busy, err;
    logic [7:0]  in_data;
    logic [7:0]  a11, a12, a21, a22, b11, b12, b21, b22;
    logic [16:0] c11, c12, c21, c22, out_data;
    logic [1:0]  out_idx;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    matmul_stream_ctrl #(.TIMEOUT(TIMEOUT), .KICK_CYCLS(KICK)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .a11(a11), .a12(a12), .a21(a21), .a22(a22), .b11(b11), .b12(b12), .b21(b21), .b22(b22),
        .arr_rst(arr_rst), .arr_done(arr_done), .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .busy(busy), .err(err)
    );

    // Array model
    logic [3:0] m_cnt;
    logic       m_stuck;

    function automatic logic signed [16:0] mulx(input logic [7:0] x, input logic [7:0] y);
        logic signed [16:0] sx, sy;
        sx = {{9{x[7]}}, x};
        sy = {{9{y[7]}}, y};
        return sx * sy;
    endfunction

    always @(posedge clk) begin
        if (arr_rst) m_cnt <= 4'd0;
        else if (m_cnt != 4'd15) m_cnt <= m_cnt + 4'd1;
    end
    assign arr_done = !m_stuck && (m_cnt >= 4'd6);
    assign c11 = mulx(a11, b11) + mulx(a12, b21);
    assign c12 = mulx(a11, b12) + mulx(a12, b22);
    assign c21 = mulx(a21, b11) + mulx(a22, b21);
    assign c22 = mulx(a21, b12) + mulx(a22, b22);

    typedef struct {
        logic [0:7][7:0]  bytes;
        logic [0:3][16:0] exp;
        logic             gapped;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: bound expired", name);
    endtask

    task automatic send_byte(input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) fail("in_ready_wait");
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic load_job(input logic [0:7][7:0] bytes, input logic gapped, input int first);
        for (int k = first; k < 8; k++) begin
            if (gapped) repeat ((k % 3) + 1) @(negedge clk);
            send_byte(bytes[k]);
        end
    endtask

    // Counts KICK cycles and WAIT cycles up to the first out_valid.
    task automatic wait_out(output int kc, output int wc);
        int n = 0;
        kc = 0;
        wc = 0;
        while (!out_valid && n < 100) begin
            if (busy && arr_rst) kc++;
            if (busy && !arr_rst) wc++;
            @(negedge clk);
            n++;
        end
        if (!out_valid) fail("out_valid_wait");
    endtask

    task automatic drain_job(input logic [0:3][16:0] exp, input logic [3:0] pat, input string tag);
        int          got = 0;
        int          cyc = 0;
        logic        stalled = 1'b0;
        logic [16:0] pd = '0;
        logic [1:0]  pi = '0;
        while (got < 4 && cyc < 200) begin
            out_ready = pat[cyc[1:0]];
            if (stalled) begin
                check({tag, "_hold_data"}, 64'(out_data), 64'(pd));
                check({tag, "_hold_idx"}, 64'(out_idx), 64'(pi));
                stalled = 1'b0;
            end
            if (out_valid) begin
                if (out_ready) begin
                    check({tag, "_data"}, 64'(out_data), 64'(exp[got]));
                    check({tag, "_idx"}, 64'(out_idx), 64'(got));
                    got++;
                end else begin
                    stalled = 1'b1;
                    pd = out_data;
                    pi = out_idx;
                end
            end
            @(negedge clk);
            cyc++;
        end
        if (got < 4) fail({tag, "_drain"});
        out_ready = 1'b1;
        check({tag, "_busy_after"}, 64'(busy), 64'd0);
        check({tag, "_valid_after"}, 64'(out_valid), 64'd0);
        check({tag, "_arr_rst_after"}, 64'(arr_rst), 64'd1);
    endtask

    function automatic logic [63:0] ops_now();
        return {a11, a12, a21, a22, b11, b12, b21, b22};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int kc, wc;
        logic saw_ready;
        logic [63:0] ops_snap;

        vecs[0] = '{bytes: {8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8},
                    exp: {17'd19, 17'd22, 17'd43, 17'd50}, gapped: 1'b0};
        vecs[1] = '{bytes: {8{8'h80}},
                    exp: {4{17'h08000}}, gapped: 1'b0};
        vecs[2] = '{bytes: {8'h7f, 8'h7f, 8'h7f, 8'h7f, 8'h80, 8'h80, 8'h80, 8'h80},
                    exp: {4{17'h18100}}, gapped: 1'b0};
        vecs[3] = '{bytes: vecs[0].bytes, exp: vecs[0].exp, gapped: 1'b1};

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; m_stuck = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_arr_rst", 64'(arr_rst), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_out_idx", 64'(out_idx), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_ops", ops_now(), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 64'(in_ready), 64'd1);

        for (int v = 0; v < 4; v++) begin
            load_job(vecs[v].bytes, vecs[v].gapped, 0);
            check($sformatf("v%0d_ops", v), ops_now(), 64'(vecs[v].bytes));
            wait_out(kc, wc);
            check($sformatf("v%0d_kick_cycles", v), 64'(kc), 64'(KICK));
            check($sformatf("v%0d_wait_cycles", v), 64'(wc), 64'd7);
            drain_job(vecs[v].exp, 4'b1111, $sformatf("v%0d", v));
            check($sformatf("v%0d_err", v), 64'(err), 64'd0);
        end

        // Consumer stalls with out_ready pattern 1,0,0,1
        load_job(vecs[0].bytes, 1'b0, 0);
        wait_out(kc, wc);
        drain_job(vecs[0].exp, 4'b1001, "stall");

        // in_valid held through KICK/WAIT must not be accepted
        load_job(vecs[2].bytes, 1'b0, 0);
        ops_snap = ops_now();
        in_valid = 1'b1;
        in_data  = 8'h55;
        saw_ready = 1'b0;
        for (int n = 0; n < 100 && !out_valid; n++) begin
            if (in_ready) saw_ready = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("held_in_ready", 64'(saw_ready), 64'd0);
        check("held_ops_stable", ops_now(), ops_snap);
        drain_job(vecs[2].exp, 4'b1111, "held");

        // Array done stuck low: timeout capture and sticky err
        m_stuck = 1'b1;
        load_job(vecs[0].bytes, 1'b0, 0);
        wait_out(kc, wc);
        check("to_wait_cycles", 64'(wc), 64'(TIMEOUT + 1));
        check("to_err_set", 64'(err), 64'd1);
        drain_job(vecs[0].exp, 4'b1111, "to");
        m_stuck = 1'b0;
        @(negedge clk);
        check("to_err_sticky", 64'(err), 64'd1);
        send_byte(vecs[0].bytes[0]);
        check("to_err_cleared", 64'(err), 64'd0);
        load_job(vecs[0].bytes, 1'b0, 1);
        wait_out(kc, wc);
        drain_job(vecs[0].exp, 4'b1111, "after_to");

        // Reset after 5 bytes discards the partial job
        for (int k = 0; k < 5; k++) send_byte(vecs[1].bytes[k]);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd0);
        check("mid_rst_arr_rst", 64'(arr_rst), 64'd1);
        check("mid_rst_ops", ops_now(), 64'd0);
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        load_job(vecs[0].bytes, 1'b0, 0);
        check("post_rst_ops", ops_now(), 64'(vecs[0].bytes));
        wait_out(kc, wc);
        drain_job(vecs[0].exp, 4'b1111, "post_rst");
        check("post_rst_err", 64'(err), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
